// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Byte lanes of a doubleword touched by an access of the given size at offset off.
  function automatic logic [7:0] lane_mask(input size_e size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  // A size-N access must sit on an N-byte boundary; bytes are never misaligned.
  function automatic logic is_misaligned(input size_e size, input logic [2:0] low);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return low[0];
      SZ_W:    return |low[1:0];
      default: return |low;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64 storage: one registered read port, one full-word write port, no reset.
module dmem_array #(
  parameter  int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [63:0]      rd_data_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [63:0]      wr_data_i
);

  logic [63:0] mem [DEPTH];
  logic [63:0] rd_data_q;

  // Write and read ports; read data holds until the next read enable.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_idx_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem[rd_idx_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: load/store with sub-doubleword sizes, extension and
// read-modify-write, one response per request.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | ready for a request; acceptance latches it and issues the read
//   ACCESS | two cycles: lane select/merge registered, then extend + write
//   RESP   | rsp_valid pulse, not ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  state_e state_q, state_d;
  logic   ph_q, ph_d;

  logic             we_q, uns_q;
  size_e            size_q;
  logic [IDX_W-1:0] idx_q;
  logic [2:0]       off_q;
  logic [63:0]      wdata_q;
  logic [63:0]      shift_q, merged_q;
  logic [63:0]      rdata_q;
  logic             err_q;

  logic             accept, mis;
  logic [63:0]      old_dw, shifted_old, wdata_sh, bit_mask, merged, ext;
  logic [7:0]       lanes;
  logic             wr_en;

  logic             unused_addr_hi;
  assign unused_addr_hi = ^req_addr[63:IDX_W+3];

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP) && !rst;
  assign accept    = req_valid && req_ready;
  assign mis       = is_misaligned(size_e'(req_size), req_addr[2:0]);
  // The write lands at the end of the second ACCESS cycle; a reset there drops it.
  assign wr_en     = (state_q == ACCESS) && ph_q && we_q && !rst;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk       (clk),
    .rd_en_i   (accept && !mis),
    .rd_idx_i  (req_addr[IDX_W+2:3]),
    .rd_data_o (old_dw),
    .wr_en_i   (wr_en),
    .wr_idx_i  (idx_q),
    .wr_data_i (merged_q)
  );

  // Lane selection for loads and byte merge for stores, from the old doubleword.
  always_comb begin
    lanes       = lane_mask(size_q, off_q);
    bit_mask    = '0;
    for (int i = 0; i < 8; i++) bit_mask[8*i +: 8] = {8{lanes[i]}};
    shifted_old = old_dw >> {off_q, 3'b000};
    wdata_sh    = wdata_q << {off_q, 3'b000};
    merged      = (old_dw & ~bit_mask) | (wdata_sh & bit_mask);
  end

  // Sign/zero extension of the right-aligned load data.
  always_comb begin
    ext = shift_q;
    case (size_q)
      SZ_B: ext = uns_q ? {56'd0, shift_q[7:0]}  : {{56{shift_q[7]}},  shift_q[7:0]};
      SZ_H: ext = uns_q ? {48'd0, shift_q[15:0]} : {{48{shift_q[15]}}, shift_q[15:0]};
      SZ_W: ext = uns_q ? {32'd0, shift_q[31:0]} : {{32{shift_q[31]}}, shift_q[31:0]};
      default: ext = shift_q;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ph_d    = 1'b0;
          state_d = mis ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!ph_q) ph_d = 1'b1;
        else       state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
    end
  end

  // Request capture and first-ACCESS pipeline registers; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= size_e'(req_size);
      uns_q   <= req_unsigned;
      idx_q   <= req_addr[IDX_W+2:3];
      off_q   <= req_addr[2:0];
      wdata_q <= req_wdata;
    end
    if (state_q == ACCESS && !ph_q) begin
      shift_q  <= shifted_old;
      merged_q <= merged;
    end
  end

  // Response data/error; held until the next response is produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept && mis) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end else if (state_q == ACCESS && ph_q) begin
      rdata_q <= we_q ? 64'd0 : ext;
      err_q   <= 1'b0;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
